// File: rtl/lane_hazard_if.sv
// Frog position in, hazard controls and lane positions out, between the
// lane_hazard engine (slave) and the player/sprite logic (master).
interface lane_hazard_if;
   logic [9:0]  BallX;
   logic [9:0]  BallY;
   logic        collision;
   logic        in_water;
   logic        success;
   logic [2:0]  shift;
   logic [79:0] lane_x;
   logic [2:0]  level;

   modport master (
      output BallX, BallY,
      input  collision, in_water, success, shift, lane_x, level
   );

   modport slave (
      input  BallX, BallY,
      output collision, in_water, success, shift, lane_x, level
   );
endinterface

// File: rtl/lane_hazard.sv
// Frogger obstacle-lane engine: four river logs, four road cars, frog hit tests.
// Optional macro LANE_SPEEDUP_EN: each success raises the level and shortens lane periods.
module lane_hazard #(
   parameter int HOLD_FRAMES = 2,
   parameter int BASE_PERIOD = 2,
   parameter int LOG_W       = 96,
   parameter int CAR_W       = 32
) (
   input logic          frame_clk,
   input logic          Reset,
   lane_hazard_if.slave bus
);
   typedef enum logic [0:0] {PLAY = 1'b0, HOLD = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [2:0]  hold_cnt_q, hold_cnt_d;
   logic [9:0]  x_q [8];
   logic [9:0]  x_d [8];
   logic [4:0]  cnt_q [8];
   logic [4:0]  cnt_d [8];
   logic        collision_q, collision_d;
   logic        in_water_q, in_water_d;
   logic        success_q, success_d;
   logic [2:0]  shift_q, shift_d;
   logic [2:0]  level_s;
   logic [5:0]  p_full_s, per_s;
   logic [10:0] dx_s, wid_s;
   logic [7:0]  step_s, ovl_s, in_lane_s;
   logic        x_valid_s, succ_s, coll_s, water_s, event_s;
   logic [2:0]  ride_shift_s;

`ifdef LANE_SPEEDUP_EN
   logic [2:0] level_q, level_d;

   // A success pulse raises the level, saturating at 7
   always_comb begin
      if (state_q == PLAY && succ_s && level_q != 3'd7) begin
         level_d = level_q + 3'd1;
      end else begin
         level_d = level_q;
      end
   end

   // Level register, cleared only by Reset
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         level_q <= 3'd0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level_s = level_q;
`else
   assign level_s = 3'd0;
`endif

   // Lane step counters and wrapping motion; period floors at one frame
   always_comb begin
      p_full_s = 6'd0;
      per_s    = 6'd1;
      step_s   = 8'd0;
      for (int i = 0; i < 8; i++) begin
         p_full_s = 6'(BASE_PERIOD) + 6'(i & 3);
         if (p_full_s > {3'd0, level_s}) begin
            per_s = p_full_s - {3'd0, level_s};
         end else begin
            per_s = 6'd1;
         end
         step_s[i] = ({1'b0, cnt_q[i]} >= (per_s - 6'd1));
         if (step_s[i]) begin
            cnt_d[i] = 5'd0;
            if ((i % 2) == 0) begin
               x_d[i] = (x_q[i] == 10'd0) ? 10'd639 : x_q[i] - 10'd1;
            end else begin
               x_d[i] = (x_q[i] == 10'd639) ? 10'd0 : x_q[i] + 10'd1;
            end
         end else begin
            cnt_d[i] = cnt_q[i] + 5'd1;
            x_d[i]   = x_q[i];
         end
      end
   end

   // Row decode and wrap-around overlap against the pre-step positions
   always_comb begin
      x_valid_s = (bus.BallX < 10'd640);
      dx_s      = 11'd0;
      wid_s     = 11'd0;
      in_lane_s = 8'd0;
      ovl_s     = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            in_lane_s[i] = (bus.BallY >= 10'(162 + 20 * i)) && (bus.BallY < 10'(182 + 20 * i));
            wid_s        = 11'(LOG_W);
         end else begin
            in_lane_s[i] = (bus.BallY >= 10'(262 + 20 * (i - 4))) && (bus.BallY < 10'(282 + 20 * (i - 4)));
            wid_s        = 11'(CAR_W);
         end
         if (bus.BallX >= x_q[i]) begin
            dx_s = {1'b0, bus.BallX} - {1'b0, x_q[i]};
         end else begin
            dx_s = {1'b0, bus.BallX} + 11'd640 - {1'b0, x_q[i]};
         end
         ovl_s[i] = x_valid_s && (dx_s < wid_s);
      end
   end

   assign succ_s  = x_valid_s && (bus.BallY < 10'd162);
   assign coll_s  = |(in_lane_s[7:4] & ovl_s[7:4]);
   assign water_s = x_valid_s && (|(in_lane_s[3:0] & ~ovl_s[3:0]));
   assign event_s = succ_s | coll_s | water_s;

   // Carry command from the river log the frog rides, on that log's step edge
   always_comb begin
      ride_shift_s = 3'b000;
      for (int i = 0; i < 4; i++) begin
         if (in_lane_s[i] && ovl_s[i] && step_s[i]) begin
            ride_shift_s = ((i % 2) == 0) ? 3'b001 : 3'b010;
         end else begin
            ride_shift_s = ride_shift_s;
         end
      end
   end

   // PLAY/HOLD next state and event outputs; HOLD blanks events and shift
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      collision_d = 1'b0;
      in_water_d  = 1'b0;
      success_d   = 1'b0;
      shift_d     = 3'b000;
      case (state_q)
         PLAY: begin
            if (event_s) begin
               state_d     = HOLD;
               hold_cnt_d  = 3'(HOLD_FRAMES - 1);
               success_d   = succ_s;
               collision_d = coll_s & ~succ_s;
               in_water_d  = water_s & ~succ_s & ~coll_s;
            end else begin
               shift_d = ride_shift_s;
            end
         end
         HOLD: begin
            if (hold_cnt_q == 3'd0) begin
               state_d = PLAY;
            end else begin
               hold_cnt_d = hold_cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = PLAY;
         end
      endcase
   end

   // State, lane and output registers
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q     <= PLAY;
         hold_cnt_q  <= 3'd0;
         collision_q <= 1'b0;
         in_water_q  <= 1'b0;
         success_q   <= 1'b0;
         shift_q     <= 3'b000;
         for (int i = 0; i < 8; i++) begin
            x_q[i]   <= 10'(80 * i);
            cnt_q[i] <= 5'd0;
         end
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         collision_q <= collision_d;
         in_water_q  <= in_water_d;
         success_q   <= success_d;
         shift_q     <= shift_d;
         for (int i = 0; i < 8; i++) begin
            x_q[i]   <= x_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.collision = collision_q;
   assign bus.in_water  = in_water_q;
   assign bus.success   = success_q;
   assign bus.shift     = shift_q;
   assign bus.level     = level_s;
   assign bus.lane_x    = {x_q[7], x_q[6], x_q[5], x_q[4], x_q[3], x_q[2], x_q[1], x_q[0]};
endmodule

// File: tb/tb_lane_hazard.sv
// Bench for lane_hazard: directed vector table, hand sequences for wrap and
// reset-in-HOLD, and random frames checked against a frame-level model.
module tb_lane_hazard;
   localparam int HOLD_FRAMES = 2;
   localparam int BASE_PERIOD = 2;
   localparam int LOG_W       = 96;
   localparam int CAR_W       = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   lane_hazard_if bus ();

   lane_hazard #(
      .HOLD_FRAMES(HOLD_FRAMES),
      .BASE_PERIOD(BASE_PERIOD),
      .LOG_W(LOG_W),
      .CAR_W(CAR_W)
   ) dut (
      .frame_clk(clk),
      .Reset(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Model: lane positions, frames since each lane last stepped, frames still muted, level
   int mx [8];
   int mage [8];
   int msup;
   int mlvl;
   logic       e_col, e_wat, e_suc;
   logic [2:0] e_sh;

   typedef struct {
      int         bx;
      int         by;
      bit         r;
      bit         col;
      bit         wat;
      bit         suc;
      logic [2:0] sh;
   } vec_t;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int lane_of(input int by);
      for (int i = 0; i < 4; i++)
         if (by >= 162 + 20 * i && by < 182 + 20 * i) return i;
      for (int i = 4; i < 8; i++)
         if (by >= 262 + 20 * (i - 4) && by < 282 + 20 * (i - 4)) return i;
      return -1;
   endfunction

   function automatic bit hit(input int ln, input int bx);
      int d;
      d = (bx - mx[ln] + 640) % 640;
      return d < ((ln < 4) ? LOG_W : CAR_W);
   endfunction

   function automatic logic [79:0] model_lanes();
      logic [79:0] v;
      for (int i = 0; i < 8; i++) v[10 * i +: 10] = 10'(mx[i]);
      return v;
   endfunction

   task automatic model_edge(input int bx, input int by, input bit r);
      int ln, ev, per;
      bit stp [8];
      e_col = 1'b0; e_wat = 1'b0; e_suc = 1'b0; e_sh = 3'b000;
      if (r) begin
         for (int i = 0; i < 8; i++) begin mx[i] = 80 * i; mage[i] = 0; end
         msup = 0;
         mlvl = 0;
         return;
      end
      ln = lane_of(by);
      ev = 0;
      if (bx < 640) begin
         if (by < 162) ev = 1;
         else if (ln >= 4 && hit(ln, bx)) ev = 2;
         else if (ln >= 0 && ln < 4 && !hit(ln, bx)) ev = 3;
      end
      for (int i = 0; i < 8; i++) begin
         per = BASE_PERIOD + (i % 4) - mlvl;
         if (per < 1) per = 1;
         stp[i] = (mage[i] + 1 >= per);
      end
      if (msup > 0) begin
         msup--;
      end else if (ev != 0) begin
         e_suc = (ev == 1);
         e_col = (ev == 2);
         e_wat = (ev == 3);
         msup  = HOLD_FRAMES;
`ifdef LANE_SPEEDUP_EN
         if (ev == 1 && mlvl < 7) mlvl++;
`endif
      end else if (bx < 640 && ln >= 0 && ln < 4 && hit(ln, bx) && stp[ln]) begin
         e_sh = ((ln % 2) == 0) ? 3'b001 : 3'b010;
      end
      for (int i = 0; i < 8; i++) begin
         if (stp[i]) begin
            mage[i] = 0;
            mx[i] = ((i % 2) == 0) ? (mx[i] + 639) % 640 : (mx[i] + 1) % 640;
         end else begin
            mage[i]++;
         end
      end
   endtask

   task automatic apply(input int bx, input int by, input bit r);
      bus.BallX = 10'(bx);
      bus.BallY = 10'(by);
      rst = r;
      model_edge(bx, by, r);
      @(posedge clk);
      #1;
      chk("collision", {79'd0, bus.collision}, {79'd0, e_col});
      chk("in_water", {79'd0, bus.in_water}, {79'd0, e_wat});
      chk("success", {79'd0, bus.success}, {79'd0, e_suc});
      chk("shift", {77'd0, bus.shift}, {77'd0, e_sh});
      chk("lane_x", bus.lane_x, model_lanes());
      chk("level", {77'd0, bus.level}, {77'd0, 3'(mlvl)});
   endtask

   vec_t tbl [19];

   initial begin
      logic [79:0] rst_lanes;
      bit seen_wrap, seen_ride;
      logic [9:0] prev1;
      int budget, ln, bx, by;

      tbl[0]  = '{0,   400, 1, 0, 0, 0, 3'b000};
      tbl[1]  = '{0,   400, 1, 0, 0, 0, 3'b000};
      tbl[2]  = '{325, 272, 0, 1, 0, 0, 3'b000};
      tbl[3]  = '{325, 272, 0, 0, 0, 0, 3'b000};
      tbl[4]  = '{325, 272, 0, 0, 0, 0, 3'b000};
      tbl[5]  = '{325, 272, 0, 1, 0, 0, 3'b000};
      tbl[6]  = '{0,   400, 0, 0, 0, 0, 3'b000};
      tbl[7]  = '{0,   400, 0, 0, 0, 0, 3'b000};
      tbl[8]  = '{197, 172, 0, 0, 1, 0, 3'b000};
      tbl[9]  = '{0,   400, 0, 0, 0, 0, 3'b000};
      tbl[10] = '{0,   400, 0, 0, 0, 0, 3'b000};
      tbl[11] = '{6,   172, 0, 0, 0, 0, 3'b001};
      tbl[12] = '{6,   172, 0, 0, 0, 0, 3'b000};
      tbl[13] = '{6,   172, 0, 0, 0, 0, 3'b001};
      tbl[14] = '{6,   172, 0, 0, 0, 0, 3'b000};
      tbl[15] = '{6,   172, 0, 0, 0, 0, 3'b001};
      tbl[16] = '{100, 150, 0, 0, 0, 1, 3'b000};
      tbl[17] = '{100, 150, 0, 0, 0, 0, 3'b000};
      tbl[18] = '{100, 150, 0, 0, 0, 0, 3'b000};

      for (int i = 0; i < 8; i++) rst_lanes[10 * i +: 10] = 10'(80 * i);

      for (int k = 0; k < 19; k++) begin
         apply(tbl[k].bx, tbl[k].by, tbl[k].r);
         chk($sformatf("tbl%0d collision", k), {79'd0, bus.collision}, {79'd0, tbl[k].col});
         chk($sformatf("tbl%0d in_water", k), {79'd0, bus.in_water}, {79'd0, tbl[k].wat});
         chk($sformatf("tbl%0d success", k), {79'd0, bus.success}, {79'd0, tbl[k].suc});
         chk($sformatf("tbl%0d shift", k), {77'd0, bus.shift}, {77'd0, tbl[k].sh});
         if (k == 1) chk("reset lane_x", bus.lane_x, rst_lanes);
      end

      // Reset inside HOLD: next frame is PLAY, the held car hit fires again
      apply(0, 400, 1'b1);
      apply(325, 272, 1'b0);
      chk("hold-reset first hit", {79'd0, bus.collision}, 80'd1);
      apply(325, 272, 1'b1);
      chk("hold-reset during reset", {79'd0, bus.collision}, 80'd0);
      apply(325, 272, 1'b0);
      chk("hold-reset re-pulse", {79'd0, bus.collision}, 80'd1);

      // Run lane 1 up to x = 630, then ride its log across the 639 -> 0 wrap
      apply(0, 400, 1'b1);
      budget = 0;
      while (mx[1] != 630 && budget < 2500) begin
         apply(300, 400, 1'b0);
         budget++;
      end
      chk("lane1 reach 630 within budget", {79'd0, (mx[1] == 630)}, 80'd1);
      seen_wrap = 1'b0;
      seen_ride = 1'b0;
      for (int k = 0; k < 40; k++) begin
         prev1 = bus.lane_x[19:10];
         apply(20, 192, 1'b0);
         if (prev1 == 10'd639 && bus.lane_x[19:10] == 10'd0) seen_wrap = 1'b1;
         if (bus.shift == 3'b010) seen_ride = 1'b1;
      end
      chk("lane1 wrap 639->0 seen", {79'd0, seen_wrap}, 80'd1);
      chk("lane1 ride shift 010 seen", {79'd0, seen_ride}, 80'd1);

      // Random frames, biased toward positions near the objects
      apply(0, 400, 1'b1);
      for (int k = 0; k < 3000; k++) begin
         by = int'($urandom_range(0, 420));
         ln = lane_of(by);
         if ($urandom_range(0, 9) == 0) bx = int'($urandom_range(640, 1023));
         else if (ln >= 0 && $urandom_range(0, 1) == 1) bx = (mx[ln] + int'($urandom_range(0, 110))) % 640;
         else bx = int'($urandom_range(0, 639));
         apply(bx, by, ($urandom_range(0, 199) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
